calc_key_entry: RTL and testbench
=================================

Name: calc_key_entry

Overview:
Input side of the 7-segment calculator. Scans a 4x4 active-low key matrix, debounces it and decodes each key press. An entry state machine turns decimal keystrokes into the binary operands A and B (0-255) and the 3-bit op code that feed the adder/subtractor/multiplier/divider datapath. It also exposes the operand currently being typed, so the top level can route it to the BCD/FND display path.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven (one column slot); must be >= 2.
DEB_SCANS, 4, consecutive identical full scan frames required to accept a press or a release; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row_n  in  4  matrix rows, active-low, externally pulled up
col_n  out  4  matrix column drive, active-low, exactly one bit low at all times
A  out  8  committed operand A
B  out  8  committed operand B
op  out  3  committed op: 0 add, 1 sub, 2 mul, 3 div, 4 mod
valid  out  1  high while A/B/op hold a committed expression
entry_val  out  8  operand currently being typed
entry_sel  out  1  0 = typing A, 1 = typing B
ovf  out  1  sticky: a digit was rejected because of overflow

Behaviour:
- Reset (async assert, sync release): col_n=4'b1110; A=B=0; op=0; valid=0; entry_val=0; entry_sel=0; ovf=0; scan counters cleared; FSM in S_A; debouncer in released state.
- Scan: a column index 0..3 advances every SCAN_DIV cycles and wraps 3->0. col_n has a 0 only at that index.
- Row sampling: row_n is sampled on the last cycle of each slot. Four slots make one frame.
- Key index = row*4+col. Keymap, row 0..3 left to right: 1 2 3 ADD / 4 5 6 SUB / 7 8 9 MUL / MOD 0 EQ DIV.
- Key codes: digits 0-9, ADD=10, SUB=11, MUL=12, DIV=13, MOD=14, EQ=15.
- Frame result: exactly one closed contact -> that code; zero or more than one closed contact -> NONE.
- Debounce:
  - In released state, DEB_SCANS consecutive frames with the same non-NONE code emit a single 1-cycle internal key event at the end of the last frame. The debouncer then enters pressed state.
  - In pressed state, DEB_SCANS consecutive NONE frames return it to released state.
  - Holding a key never repeats. A different code while pressed generates no event.
- Entry FSM, acting on key events only:
  - S_A:
    - digit d -> acc = acc*10+d if the result is <= 255, else acc unchanged and ovf=1.
    - op key -> if at least one digit has been entered: latch pending op, acc=0, entry_sel=1, go to S_B; else ignore.
    - EQ -> clear (acc=0, ovf=0, digit count=0).
  - S_B:
    - digit d -> same accumulation rule into B.
    - op key -> replace pending op.
    - EQ with at least one B digit -> A<=A_acc, B<=B_acc, op<=pending, valid=1, go to S_DONE.
    - EQ with no B digit -> full clear to S_A (entry_sel=0, ovf=0).
  - S_DONE:
    - digit d -> valid=0, A accumulator=d, entry_sel=0, ovf=0, go to S_A.
    - op key -> ignored.
    - EQ -> valid=0, full clear to S_A.
- A, B and op change only on commit. valid falls in the same cycle the FSM leaves S_DONE.
- entry_val = accumulator of the operand in entry; it is registered and updates the cycle after the key event. In S_DONE it shows committed B.
- Width rule: compute acc*10+d in at least 12 bits, then compare against 255.
- Reset mid-press: returns to the reset state. A key still held after reset must pass full debounce and generates one event.

Decomposition:
- Shared package calc_pkg: key codes KEY_0..KEY_9, KEY_ADD..KEY_EQ, KEY_NONE; OP_ADD..OP_MOD (3-bit); FSM state encoding S_A/S_B/S_DONE; the 16-entry keymap constant.
- One sub-module, key_scan_debounce: column drive, row sampling, frame decode and debounce. Outputs key_evt and key_code.
- The entry FSM stays in calc_key_entry.

Test Plan (SCAN_DIV=4, DEB_SCANS=2):
- Press "1","2","3",ADD,"4","5",EQ, each held 3 frames then released 3 frames -> entry_val steps 1,12,123,0,4,45; A=123, B=45, op=0, valid=1.
- "2","5","6" -> 256 is rejected: entry_val=25, ovf=1. Then EQ -> entry_val=0, ovf=0.
- Hold "7" for 20 frames -> exactly one event, entry_val=7. Bounce "7" for 1 frame on / 1 frame off -> no event.
- Press "3" and "6" together -> no event. Release, then press "6" alone -> entry_val=6.
- "9",SUB,MOD,"2",EQ -> op=4, A=9, B=2. Then "5" -> valid=0, entry_val=5, entry_sel=0.
- Assert rst_n low mid-way through entering B -> all outputs at reset values within 1 cycle; col_n=1110.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg -- key codes, op codes, entry states and keymap for the calculator
// Rev 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_0    = 5'd0;
  localparam key_code_t KEY_1    = 5'd1;
  localparam key_code_t KEY_2    = 5'd2;
  localparam key_code_t KEY_3    = 5'd3;
  localparam key_code_t KEY_4    = 5'd4;
  localparam key_code_t KEY_5    = 5'd5;
  localparam key_code_t KEY_6    = 5'd6;
  localparam key_code_t KEY_7    = 5'd7;
  localparam key_code_t KEY_8    = 5'd8;
  localparam key_code_t KEY_9    = 5'd9;
  localparam key_code_t KEY_ADD  = 5'd10;
  localparam key_code_t KEY_SUB  = 5'd11;
  localparam key_code_t KEY_MUL  = 5'd12;
  localparam key_code_t KEY_DIV  = 5'd13;
  localparam key_code_t KEY_MOD  = 5'd14;
  localparam key_code_t KEY_EQ   = 5'd15;
  localparam key_code_t KEY_NONE = 5'd16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } entry_state_e;

  // Indexed by row*4+col.
  localparam key_code_t KEYMAP [16] = '{
    KEY_1,   KEY_2, KEY_3,  KEY_ADD,
    KEY_4,   KEY_5, KEY_6,  KEY_SUB,
    KEY_7,   KEY_8, KEY_9,  KEY_MUL,
    KEY_MOD, KEY_0, KEY_EQ, KEY_DIV
  };

  function automatic logic is_digit(input key_code_t k);
    return (k <= KEY_9);
  endfunction

  function automatic logic is_op(input key_code_t k);
    return (k >= KEY_ADD) && (k <= KEY_MOD);
  endfunction

  function automatic logic [2:0] key_to_op(input key_code_t k);
    logic [2:0] op;
    case (k)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      KEY_MOD: op = OP_MOD;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_scan_debounce -- 4x4 matrix column scan, frame decode and debounce
// Rev 1.0
// ---------------------------------------------------------------------------
module key_scan_debounce
  import calc_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_evt,
  output logic [4:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_SCANS + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       hits_q, hits_d;     // closed contacts so far this frame, saturates at 2
  key_code_t        fcode_q, fcode_d;
  logic             pressed_q, pressed_d;
  key_code_t        cand_q, cand_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  key_code_t        code_q, code_d;

  logic             slot_end, frame_end;
  logic [1:0]       slot_hits, tot_hits;
  key_code_t        slot_code, merged_code, frame_res;
  logic [DEB_W-1:0] cnt_n;

  assign slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (col_q == 2'd3);
  assign col_n     = ~(4'b0001 << col_q);
  assign key_evt   = evt_q;
  assign key_code  = code_q;

  always_comb begin
    slot_hits = 2'd0;
    slot_code = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        slot_code = KEYMAP[{r[1:0], col_q}];
        if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
      end
    end
    if (hits_q == 2'd0)         tot_hits = slot_hits;
    else if (slot_hits == 2'd0) tot_hits = hits_q;
    else                        tot_hits = 2'd2;
    merged_code = (slot_hits != 2'd0) ? slot_code : fcode_q;
    frame_res   = (tot_hits == 2'd1) ? merged_code : KEY_NONE;
  end

  always_comb begin
    div_d     = slot_end ? '0 : div_q + DIV_W'(1);
    col_d     = slot_end ? col_q + 2'd1 : col_q;
    hits_d    = hits_q;
    fcode_d   = fcode_q;
    pressed_d = pressed_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    evt_d     = 1'b0;
    code_d    = code_q;
    cnt_n     = cnt_q;

    if (frame_end) begin
      hits_d  = 2'd0;
      fcode_d = KEY_NONE;
      if (!pressed_q) begin
        if (frame_res == KEY_NONE) begin
          cnt_d = '0;
        end else begin
          if ((frame_res == cand_q) && (cnt_q != '0)) begin
            cnt_n = cnt_q + DEB_W'(1);
          end else begin
            cand_d = frame_res;
            cnt_n  = DEB_W'(1);
          end
          if (cnt_n == DEB_W'(DEB_SCANS)) begin
            evt_d     = 1'b1;
            code_d    = frame_res;
            pressed_d = 1'b1;
            cnt_n     = '0;
          end
          cnt_d = cnt_n;
        end
      end else begin
        // A different code while pressed just restarts the release count.
        if (frame_res == KEY_NONE) begin
          cnt_n = cnt_q + DEB_W'(1);
          if (cnt_n == DEB_W'(DEB_SCANS)) begin
            pressed_d = 1'b0;
            cnt_n     = '0;
          end
          cnt_d = cnt_n;
        end else begin
          cnt_d = '0;
        end
      end
    end else if (slot_end) begin
      hits_d  = tot_hits;
      fcode_d = merged_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_q     <= 2'd0;
      hits_q    <= 2'd0;
      fcode_q   <= KEY_NONE;
      pressed_q <= 1'b0;
      cand_q    <= KEY_NONE;
      cnt_q     <= '0;
      evt_q     <= 1'b0;
      code_q    <= KEY_NONE;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      hits_q    <= hits_d;
      fcode_q   <= fcode_d;
      pressed_q <= pressed_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      code_q    <= code_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_key_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_key_entry -- keypad scan plus decimal operand/op entry state machine
// Rev 1.0
// ---------------------------------------------------------------------------
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] op,
  output logic       valid,
  output logic [7:0] entry_val,
  output logic       entry_sel,
  output logic       ovf
);

  logic      key_evt;
  key_code_t key_code;

  key_scan_debounce #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_SCANS(DEB_SCANS)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_n   (row_n),
    .col_n   (col_n),
    .key_evt (key_evt),
    .key_code(key_code)
  );

  entry_state_e state_q, state_d;
  logic [7:0]   acc_a_q, acc_a_d;
  logic [7:0]   acc_b_q, acc_b_d;
  logic         has_a_q, has_a_d;
  logic         has_b_q, has_b_d;
  logic [2:0]   pend_q, pend_d;
  logic [7:0]   a_q, a_d;
  logic [7:0]   b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         sel_q, sel_d;
  logic [7:0]   val_q, val_d;

  logic [7:0]   cur_acc;
  logic [11:0]  prod;
  logic         fits;

  // 12 bits so 255*10+9 cannot wrap before the range test.
  assign cur_acc = (state_q == S_B) ? acc_b_q : acc_a_q;
  assign prod    = 12'(cur_acc) * 12'd10 + 12'(key_code);
  assign fits    = (prod <= 12'd255);

  always_comb begin
    state_d = state_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    has_a_d = has_a_q;
    has_b_d = has_b_q;
    pend_d  = pend_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (key_evt) begin
      case (state_q)
        S_A: begin
          if (is_digit(key_code)) begin
            if (fits) begin
              acc_a_d = prod[7:0];
              has_a_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (is_op(key_code)) begin
            if (has_a_q) begin
              pend_d  = key_to_op(key_code);
              acc_b_d = 8'd0;
              has_b_d = 1'b0;
              state_d = S_B;
            end
          end else if (key_code == KEY_EQ) begin
            acc_a_d = 8'd0;
            has_a_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        S_B: begin
          if (is_digit(key_code)) begin
            if (fits) begin
              acc_b_d = prod[7:0];
              has_b_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (is_op(key_code)) begin
            pend_d = key_to_op(key_code);
          end else if (key_code == KEY_EQ) begin
            if (has_b_q) begin
              a_d     = acc_a_q;
              b_d     = acc_b_q;
              op_d    = pend_q;
              valid_d = 1'b1;
              state_d = S_DONE;
            end else begin
              acc_a_d = 8'd0;
              acc_b_d = 8'd0;
              has_a_d = 1'b0;
              has_b_d = 1'b0;
              ovf_d   = 1'b0;
              state_d = S_A;
            end
          end
        end
        S_DONE: begin
          if (is_digit(key_code)) begin
            valid_d = 1'b0;
            acc_a_d = 8'(key_code);
            has_a_d = 1'b1;
            acc_b_d = 8'd0;
            has_b_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_A;
          end else if (key_code == KEY_EQ) begin
            valid_d = 1'b0;
            acc_a_d = 8'd0;
            acc_b_d = 8'd0;
            has_a_d = 1'b0;
            has_b_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end

    sel_d = (state_d != S_A);
    case (state_d)
      S_A:     val_d = acc_a_d;
      S_B:     val_d = acc_b_d;
      default: val_d = b_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      acc_a_q <= 8'd0;
      acc_b_q <= 8'd0;
      has_a_q <= 1'b0;
      has_b_q <= 1'b0;
      pend_q  <= OP_ADD;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      op_q    <= OP_ADD;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
      val_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      has_a_q <= has_a_d;
      has_b_q <= has_b_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;
  assign valid     = valid_q;
  assign entry_val = val_q;
  assign entry_sel = sel_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_calc_key_entry -- keypad-model bench for calc_key_entry (SCAN_DIV=4, DEB_SCANS=2)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_calc_key_entry;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  // Key masks, bit index = row*4+col.
  localparam logic [15:0] K1   = 16'h0001;
  localparam logic [15:0] K2   = 16'h0002;
  localparam logic [15:0] K3   = 16'h0004;
  localparam logic [15:0] KADD = 16'h0008;
  localparam logic [15:0] K4   = 16'h0010;
  localparam logic [15:0] K5   = 16'h0020;
  localparam logic [15:0] K6   = 16'h0040;
  localparam logic [15:0] KSUB = 16'h0080;
  localparam logic [15:0] K7   = 16'h0100;
  localparam logic [15:0] K9   = 16'h0400;
  localparam logic [15:0] KMOD = 16'h1000;
  localparam logic [15:0] KEQ  = 16'h4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] A, B, entry_val;
  logic [2:0] op;
  logic       valid, entry_sel, ovf;

  logic [15:0] keys_down = 16'h0000;

  int checks = 0;
  int errors = 0;

  calc_key_entry #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_SCANS(DEB_SCANS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .A        (A),
    .B        (B),
    .op       (op),
    .valid    (valid),
    .entry_val(entry_val),
    .entry_sel(entry_sel),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          rel;
    logic [7:0]  val;
    logic        sel;
    logic        ovf;
    logic        valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [15:0] k, input int hold, input int rel);
    keys_down = k;
    repeat (hold * FRAME) @(negedge clk);
    keys_down = 16'h0000;
    repeat (rel * FRAME) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [7:0] v, input logic s, input logic o,
                           input logic vl, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] p);
    check({tag, " entry_val"}, 32'(entry_val), 32'(v));
    check({tag, " entry_sel"}, 32'(entry_sel), 32'(s));
    check({tag, " ovf"},       32'(ovf),       32'(o));
    check({tag, " valid"},     32'(valid),     32'(vl));
    check({tag, " A"},         32'(A),         32'(a));
    check({tag, " B"},         32'(B),         32'(b));
    check({tag, " op"},        32'(op),        32'(p));
  endtask

  task automatic run_vec(input int i);
    press(vecs[i].keys, vecs[i].hold, vecs[i].rel);
    check_all($sformatf("v%0d", i), vecs[i].val, vecs[i].sel, vecs[i].ovf,
              vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].op);
  endtask

  initial begin
    //          keys        hold rel val   sel   ovf   valid A       B      op
    vecs[0]  = '{K1,          3, 3, 8'd1,   1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[1]  = '{K2,          3, 3, 8'd12,  1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[2]  = '{K3,          3, 3, 8'd123, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[3]  = '{KADD,        3, 3, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[4]  = '{K4,          3, 3, 8'd4,   1'b1, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[5]  = '{K5,          3, 3, 8'd45,  1'b1, 1'b0, 1'b0, 8'd0,   8'd0,  3'd0};
    vecs[6]  = '{KEQ,         3, 3, 8'd45,  1'b1, 1'b0, 1'b1, 8'd123, 8'd45, 3'd0};
    vecs[7]  = '{K2,          3, 3, 8'd2,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[8]  = '{K5,          3, 3, 8'd25,  1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[9]  = '{K6,          3, 3, 8'd25,  1'b0, 1'b1, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[10] = '{KEQ,         3, 3, 8'd0,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[11] = '{K7,         20, 3, 8'd7,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[12] = '{KEQ,         3, 3, 8'd0,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[13] = '{K3 | K6,     3, 3, 8'd0,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[14] = '{K6,          3, 3, 8'd6,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[15] = '{KEQ,         3, 3, 8'd0,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[16] = '{K9,          3, 3, 8'd9,   1'b0, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[17] = '{KSUB,        3, 3, 8'd0,   1'b1, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[18] = '{KMOD,        3, 3, 8'd0,   1'b1, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[19] = '{K2,          3, 3, 8'd2,   1'b1, 1'b0, 1'b0, 8'd123, 8'd45, 3'd0};
    vecs[20] = '{KEQ,         3, 3, 8'd2,   1'b1, 1'b0, 1'b1, 8'd9,   8'd2,  3'd4};
    vecs[21] = '{K5,          3, 3, 8'd5,   1'b0, 1'b0, 1'b0, 8'd9,   8'd2,  3'd4};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
    check("reset col_n", 32'(col_n), 32'(4'b1110));

    // Column walks one step every SCAN_DIV cycles after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("scan col_n cyc%0d", i), 32'(col_n),
            32'((i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : 4'b1011));
    end

    for (int i = 0; i <= 11; i++) run_vec(i);

    // Bounce: 1 frame on / 1 frame off never gives two matching frames in a row.
    for (int n = 0; n < 4; n++) press(K7, 1, 1);
    repeat (2 * FRAME) @(negedge clk);
    check("bounce entry_val", 32'(entry_val), 32'd7);

    for (int i = 12; i <= 21; i++) run_vec(i);

    // Reset while B entry is in progress and a key is held through reset.
    press(KADD, 3, 3);
    press(K3, 3, 3);
    check("pre-rst entry_val", 32'(entry_val), 32'd3);
    check("pre-rst entry_sel", 32'(entry_sel), 32'd1);
    keys_down = K4;
    repeat (5 * FRAME) @(negedge clk);
    check("held entry_val", 32'(entry_val), 32'd34);
    #2 rst_n = 1'b0;
    #1;
    check_all("midrst", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);
    check("midrst col_n", 32'(col_n), 32'(4'b1110));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * FRAME) @(negedge clk);
    keys_down = 16'h0000;
    repeat (3 * FRAME) @(negedge clk);
    check_all("post-rst", 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
